ser_rx_word: RTL

Parametrised serial-to-parallel receiver, next generation of the 8-bit flush-capable bit collector. Samples one serial bit per enabled rising clock edge into a word of configurable width, with selectable bit order and optional parity. Presents each completed word on a held parallel output with a one-cycle valid strobe. Sits between a serial link front end and word-oriented consumers (FIFOs, register files).

---
 rtl/ser_rx_word_if.sv | 15 +
 rtl/ser_rx_word.sv | 84 ++++++++
 2 files changed

// File: rtl/ser_rx_word_if.sv
// ser_rx_word_if: serial input and parallel word outputs of the word receiver
interface ser_rx_word_if #(parameter int WIDTH = 8);
  localparam int CW = $clog2(WIDTH + 1);
  logic en;
  logic din;
  logic flush;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic par_err;
  logic busy;
  logic [CW-1:0] bit_cnt;
  logic [7:0] frame_cnt;
  modport master(output en, din, flush, input dout, dout_valid, par_err, busy, bit_cnt, frame_cnt);
  modport slave(input en, din, flush, output dout, dout_valid, par_err, busy, bit_cnt, frame_cnt);
endinterface

// File: rtl/ser_rx_word.sv
// ser_rx_word: serial-to-parallel word receiver with bit order, optional parity and flush
module ser_rx_word #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  ser_rx_word_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  typedef enum logic {S_DATA, S_PAR} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, dout_q, dout_d, sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] fc_q, fc_d;
  logic dv_q, dv_d, pe_q, pe_d, par_ok;
  assign sh = (LSB_FIRST != 0) ? {bus.din, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], bus.din};
  assign par_ok = ((^sr_q) ^ bus.din) == (PARITY == 2);
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    fc_d    = fc_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    if (bus.flush) begin
      state_d = S_DATA;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (bus.en) begin
      if (state_q == S_PAR) begin
        dout_d  = par_ok ? sr_q : dout_q;
        dv_d    = par_ok;
        pe_d    = !par_ok;
        fc_d    = par_ok ? fc_q + 8'd1 : fc_q;
        sr_d    = '0;
        cnt_d   = '0;
        state_d = S_DATA;
      end else if (cnt_q == LAST && PARITY == 0) begin
        dout_d = sh;
        dv_d   = 1'b1;
        fc_d   = fc_q + 8'd1;
        sr_d   = '0;
        cnt_d  = '0;
      end else if (cnt_q == LAST) begin
        sr_d    = sh;
        cnt_d   = FULL;
        state_d = S_PAR;
      end else begin
        sr_d  = sh;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DATA;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      fc_q    <= '0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      fc_q    <= fc_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
    end
  end
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.par_err    = pe_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.frame_cnt  = fc_q;
  assign bus.busy       = (cnt_q != '0) || (state_q == S_PAR);
endmodule
